// File: rtl/im_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : im_boot_loader
//  Purpose  : Holds the cpu in reset while a program image streams in over a
//             byte-wide valid/ready interface. Big-endian 16-bit words are
//             written into instruction memory at PC-compatible byte
//             addresses. An XOR checksum is then verified, and the cpu is
//             released only when that checksum matches.
//             Image: [N][hi0][lo0]...[hi(N-1)][lo(N-1)][C]
//             C = XOR of N and all 2N payload bytes.
//  Ports    : clk, reset       - clock, async active-high reset
//             in_data/valid    - image byte stream (input)
//             in_ready         - byte accepted this cycle when valid
//             restart          - reload request (honoured in RUN/ERR only)
//             im_we/addr/wdata - instruction memory write port
//             cpu_reset        - cpu reset, low only in RUN
//             done / error     - load succeeded / load rejected
//  Revision : 1.0 - initial release
// ============================================================================
module im_boot_loader #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_WORDS = 128,
    parameter int ADDR_STEP = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    // Header is a byte; widen by one bit so any MAX_WORDS up to 511 compares cleanly.
    localparam logic [8:0] C_MAX_WORDS = 9'(MAX_WORDS);

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_HI   = 3'd1,
        ST_LO   = 3'd2,
        ST_CSUM = 3'd3,
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    state_t              state_q,     state_d;
    logic [7:0]          nwords_q,    nwords_d;
    logic [7:0]          index_q,     index_d;
    logic [7:0]          acc_q,       acc_d;
    logic [7:0]          hi_q,        hi_d;
    logic                im_we_q,     im_we_d;
    logic [ADDR_W-1:0]   im_addr_q,   im_addr_d;
    logic [DATA_W-1:0]   im_wdata_q,  im_wdata_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                done_q,      done_d;
    logic                error_q,     error_d;

    logic                accept;

    assign in_ready = (state_q == ST_HDR) || (state_q == ST_HI) ||
                      (state_q == ST_LO)  || (state_q == ST_CSUM);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        nwords_d    = nwords_q;
        index_d     = index_q;
        acc_d       = acc_q;
        hi_d        = hi_q;
        im_we_d     = 1'b0;          // write strobe is a single-cycle pulse
        im_addr_d   = im_addr_q;
        im_wdata_d  = im_wdata_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            ST_HDR: begin
                if (accept) begin
                    nwords_d = in_data;
                    acc_d    = in_data;
                    index_d  = 8'd0;
                    if ((in_data == 8'd0) || ({1'b0, in_data} > C_MAX_WORDS)) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = ST_HI;
                    end
                end
            end

            ST_HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    acc_d   = acc_q ^ in_data;
                    state_d = ST_LO;
                end
            end

            ST_LO: begin
                if (accept) begin
                    acc_d      = acc_q ^ in_data;
                    im_we_d    = 1'b1;
                    im_wdata_d = DATA_W'({hi_q, in_data});
                    im_addr_d  = ADDR_W'(32'(index_q) * ADDR_STEP);
                    // The header check guarantees index never passes N-1,
                    // so the address stays inside the MAX_WORDS window.
                    if (index_q == (nwords_q - 8'd1)) begin
                        state_d = ST_CSUM;
                    end else begin
                        index_d = index_q + 8'd1;
                        state_d = ST_HI;
                    end
                end
            end

            ST_CSUM: begin
                if (accept) begin
                    // acc_q excludes the checksum byte itself.
                    if (in_data == acc_q) begin
                        state_d     = ST_RUN;
                        cpu_reset_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
            end

            ST_RUN, ST_ERR: begin
                // Memory contents and the last write address/data are left
                // alone so a reload overwrites them naturally.
                if (restart) begin
                    state_d     = ST_HDR;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    acc_d       = 8'd0;
                    index_d     = 8'd0;
                end
            end

            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HDR;
            nwords_q    <= 8'd0;
            index_q     <= 8'd0;
            acc_q       <= 8'd0;
            hi_q        <= 8'd0;
            im_we_q     <= 1'b0;
            im_addr_q   <= '0;
            im_wdata_q  <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            nwords_q    <= nwords_d;
            index_q     <= index_d;
            acc_q       <= acc_d;
            hi_q        <= hi_d;
            im_we_q     <= im_we_d;
            im_addr_q   <= im_addr_d;
            im_wdata_q  <= im_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign im_we     = im_we_q;
    assign im_addr   = im_addr_q;
    assign im_wdata  = im_wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_im_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_im_boot_loader
//  Purpose  : Directed self-checking bench for im_boot_loader. Each scenario
//             task drives an image and compares outputs against
//             hand-computed values. IM writes are captured into a queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_im_boot_loader;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 16;
    localparam int MAX_WORDS = 128;
    localparam int ADDR_STEP = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              restart;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    int checks = 0;
    int errors = 0;

    logic [23:0] wr_q[$];      // {addr, data} of each IM write
    logic [7:0]  img_q[$];     // bytes of the image to send
    logic        we_prev = 1'b0;
    logic        we_b2b  = 1'b0;

    im_boot_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS), .ADDR_STEP(ADDR_STEP)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .restart(restart), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we) wr_q.push_back({im_addr, im_wdata});
        if (im_we && we_prev) we_b2b = 1'b1;
        we_prev = im_we;
    end

    // Present one byte after 'gap' idle cycles; returns 1 time unit after the
    // accepting edge. A byte that is never accepted counts as a failure.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'hEE;
        end
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout byte %02h not accepted, in_ready=%0b want 1", b, in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_img(input int max_gap);
        foreach (img_q[i]) send_byte(img_q[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    endtask

    task automatic end_stream();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic do_restart();
        @(negedge clk);
        in_valid = 1'b0;
        restart  = 1'b1;
        @(posedge clk);
        #1;
        restart  = 1'b0;
    endtask

    task automatic load_nominal(input logic [7:0] csum);
        img_q.delete();
        img_q.push_back(8'h02); img_q.push_back(8'h12); img_q.push_back(8'h34);
        img_q.push_back(8'hAB); img_q.push_back(8'hCD); img_q.push_back(csum);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; restart = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (im_we !== 1'b0)      begin errors++; $display("FAIL reset_im_we got %0b want 0", im_we); end
        checks++; if (im_addr !== 8'h00)   begin errors++; $display("FAIL reset_im_addr got %02h want 00", im_addr); end
        checks++; if (im_wdata !== 16'h0)  begin errors++; $display("FAIL reset_im_wdata got %04h want 0000", im_wdata); end
        checks++; if (cpu_reset !== 1'b1)  begin errors++; $display("FAIL reset_cpu_reset got %0b want 1", cpu_reset); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_done_error got %0b%0b want 00", done, error); end
    endtask

    // Checksum of 02,12,34,AB,CD is 02^12^34^AB^CD = 42.
    task automatic test_nominal();
        wr_q.delete(); we_b2b = 1'b0;
        load_nominal(8'h42);
        for (int i = 0; i < 5; i++) send_byte(img_q[i], 0);
        checks++; if (cpu_reset !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL nom_pre_csum cpu_reset=%0b done=%0b want 1 0", cpu_reset, done); end
        send_byte(img_q[5], 0);
        checks++; if (cpu_reset !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL nom_release cpu_reset=%0b done=%0b want 0 1", cpu_reset, done); end
        checks++; if (in_ready !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL nom_run in_ready=%0b error=%0b want 0 0", in_ready, error); end
        // Bytes offered in RUN must be ignored.
        @(negedge clk); in_data = 8'h55; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        checks++; if (wr_q.size() != 2) begin errors++; $display("FAIL nom_wr_count got %0d want 2", wr_q.size()); end
        else begin
            checks++; if (wr_q[0] !== 24'h00_1234) begin errors++; $display("FAIL nom_wr0 got %06h want 001234", wr_q[0]); end
            checks++; if (wr_q[1] !== 24'h02_ABCD) begin errors++; $display("FAIL nom_wr1 got %06h want 02abcd", wr_q[1]); end
        end
        checks++; if (we_b2b !== 1'b0) begin errors++; $display("FAIL nom_we_b2b got %0b want 0", we_b2b); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL nom_run_hold done=%0b want 1", done); end
        do_restart();
        checks++; if (cpu_reset !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL nom_restart cpu_reset=%0b done=%0b in_ready=%0b want 1 0 1", cpu_reset, done, in_ready); end
        checks++; if (im_addr !== 8'h02 || im_wdata !== 16'hABCD) begin errors++; $display("FAIL nom_restart_hold addr=%02h data=%04h want 02 abcd", im_addr, im_wdata); end
    endtask

    // restart while loading must not disturb the load.
    task automatic test_restart_ignored();
        wr_q.delete();
        load_nominal(8'h42);
        send_byte(img_q[0], 0);
        send_byte(img_q[1], 0);
        do_restart();
        for (int i = 2; i < 6; i++) send_byte(img_q[i], 0);
        end_stream();
        checks++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin errors++; $display("FAIL rstign_run done=%0b cpu_reset=%0b want 1 0", done, cpu_reset); end
        checks++; if (wr_q.size() != 2 || wr_q[0] !== 24'h00_1234) begin errors++; $display("FAIL rstign_writes count=%0d want 2 with 001234 first", wr_q.size()); end
        do_restart();
    endtask

    task automatic test_csum_error();
        wr_q.delete();
        load_nominal(8'h41);
        send_img(0);
        checks++; if (error !== 1'b1 || cpu_reset !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL csum_err error=%0b cpu_reset=%0b in_ready=%0b want 1 1 0", error, cpu_reset, in_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL csum_err_done got %0b want 0", done); end
        end_stream();
        repeat (2) @(negedge clk);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL csum_err_park error=%0b want 1", error); end
        do_restart();
        checks++; if (error !== 1'b0 || in_ready !== 1'b1 || cpu_reset !== 1'b1) begin errors++; $display("FAIL csum_restart error=%0b in_ready=%0b cpu_reset=%0b want 0 1 1", error, in_ready, cpu_reset); end
    endtask

    task automatic test_bad_header();
        logic [7:0] hdrs [2];
        hdrs[0] = 8'h00;
        hdrs[1] = 8'h81;
        for (int h = 0; h < 2; h++) begin
            wr_q.delete();
            send_byte(hdrs[h], 0);
            checks++; if (error !== 1'b1 || in_ready !== 1'b0 || cpu_reset !== 1'b1) begin errors++; $display("FAIL badhdr_%02h error=%0b in_ready=%0b cpu_reset=%0b want 1 0 1", hdrs[h], error, in_ready, cpu_reset); end
            @(negedge clk); in_data = 8'h12; in_valid = 1'b1;
            repeat (3) @(negedge clk);
            in_valid = 1'b0;
            checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL badhdr_%02h_we writes=%0d want 0", hdrs[h], wr_q.size()); end
            do_restart();
            checks++; if (error !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL badhdr_%02h_restart error=%0b in_ready=%0b want 0 1", hdrs[h], error, in_ready); end
        end
    endtask

    task automatic test_reset_mid();
        load_nominal(8'h42);
        send_byte(img_q[0], 0);
        send_byte(img_q[1], 0);
        send_byte(img_q[2], 0);   // word 0 written on the following cycle
        checks++; if (im_we !== 1'b1) begin errors++; $display("FAIL rstmid_pre_we got %0b want 1", im_we); end
        reset = 1'b1;
        #1;
        checks++; if (im_we !== 1'b0 || cpu_reset !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_async im_we=%0b cpu_reset=%0b in_ready=%0b want 0 1 1", im_we, cpu_reset, in_ready); end
        checks++; if (im_addr !== 8'h00 || im_wdata !== 16'h0000) begin errors++; $display("FAIL rstmid_regs addr=%02h data=%04h want 00 0000", im_addr, im_wdata); end
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_stalls();
        wr_q.delete(); we_b2b = 1'b0;
        load_nominal(8'h42);
        send_img(5);
        end_stream();
        checks++; if (wr_q.size() != 2) begin errors++; $display("FAIL stall_wr_count got %0d want 2", wr_q.size()); end
        else begin
            checks++; if (wr_q[0] !== 24'h00_1234 || wr_q[1] !== 24'h02_ABCD) begin errors++; $display("FAIL stall_wr got %06h %06h want 001234 02abcd", wr_q[0], wr_q[1]); end
        end
        checks++; if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL stall_run done=%0b cpu_reset=%0b error=%0b want 1 0 0", done, cpu_reset, error); end
        checks++; if (we_b2b !== 1'b0) begin errors++; $display("FAIL stall_we_b2b got %0b want 0", we_b2b); end
        do_restart();
    endtask

    // Word k = {k,k}; each word XORs to zero, so the checksum equals N = 80.
    task automatic test_max();
        int bad;
        wr_q.delete(); we_b2b = 1'b0;
        img_q.delete();
        img_q.push_back(8'h80);
        for (int k = 0; k < 128; k++) begin
            img_q.push_back(8'(k));
            img_q.push_back(8'(k));
        end
        img_q.push_back(8'h80);
        send_img(0);
        end_stream();
        checks++; if (wr_q.size() != 128) begin errors++; $display("FAIL max_wr_count got %0d want 128", wr_q.size()); end
        else begin
            bad = -1;
            for (int k = 0; k < 128; k++)
                if (bad < 0 && wr_q[k] !== {8'(2 * k), 8'(k), 8'(k)}) bad = k;
            checks++; if (bad >= 0) begin errors++; $display("FAIL max_wr_word %0d got %06h want %02h%02h%02h", bad, wr_q[bad], 8'(2 * bad), 8'(bad), 8'(bad)); end
            checks++; if (wr_q[127] !== 24'hFE_7F7F) begin errors++; $display("FAIL max_last got %06h want fe7f7f", wr_q[127]); end
        end
        checks++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin errors++; $display("FAIL max_run done=%0b cpu_reset=%0b want 1 0", done, cpu_reset); end
        checks++; if (we_b2b !== 1'b0) begin errors++; $display("FAIL max_we_b2b got %0b want 0", we_b2b); end
        do_restart();
        checks++; if (cpu_reset !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL max_restart cpu_reset=%0b done=%0b want 1 0", cpu_reset, done); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_restart_ignored();
        test_csum_error();
        test_bad_header();
        test_reset_mid();
        test_stalls();
        test_max();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
